match_game_controller: RTL and testbench
========================================

// Module: match_game_controller
// PURPOSE
//  Sequencing controller for the two-player match-stick game. Debounces the raw pushbuttons,
//  validates each take against the dipswitch value, and keeps the remaining-match count and the
//  current player. It converts the count to BCD with a sequential double-dabble and drives the
//  16-bit word {player, hundreds, tens, ones} into the existing four-digit seven-segment driver.
// PARAMETERS
//  START_COUNT      100  matches at game start; range 1..255
//  MAX_TAKE         10   largest legal take per move; range 1..15
//  DEBOUNCE_CYCLES  16   consecutive stable cycles needed to accept a press or a release; >=2
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  dipswitches  in   4   requested take amount, unsigned
//  btn_take_n   in   1   raw "take" pushbutton, active-low
//  btn_new_n    in   1   raw "new game" pushbutton, active-low
//  disp_data    out  16  {player nibble, BCD hundreds, BCD tens, BCD ones} to the seven-seg driver
//  remaining    out  8   binary count of matches left
//  player       out  2   player to move: 2'd1 or 2'd2
//  move_err     out  1   last attempted take was illegal; held until the next legal take or new game
//  game_over    out  1   high once the count reaches 0
//  busy         out  1   high in APPLY and CONVERT
// BEHAVIOUR
//  Reset (async assert, sync release): remaining=START_COUNT, player=1, move_err=0, game_over=0,
//   busy=0, disp_data={4'h1, BCD(START_COUNT)} from an elaboration-time constant, FSM=IDLE.
//   Any in-flight conversion is discarded.
//  Both buttons pass through a 2-FF synchroniser; the internal press level is the inverted sync output.
//  FSM states: IDLE -> APPLY -> CONVERT -> WAIT_REL -> IDLE.
//   IDLE: a per-button counter counts consecutive pressed cycles and clears on any released cycle.
//    The counter reaching DEBOUNCE_CYCLES accepts that press; dipswitches are sampled on that edge.
//    If both buttons qualify on the same cycle, new game wins and the take is dropped.
//   APPLY (1 cycle):
//    new game: restore all reset values except disp_data, which is refreshed through CONVERT.
//    take with game_over=1: ignored; no state changes; go directly to WAIT_REL.
//    legal take (1<=d<=MAX_TAKE and d<=remaining): remaining-=d, move_err=0.
//     If the result is 0: game_over=1 and player is unchanged (this player took the last match).
//     Otherwise player toggles 1<->2.
//    illegal take: move_err=1; remaining and player unchanged; disp_data={player,12'hEEE} on the
//     next edge; skip CONVERT and go to WAIT_REL.
//   CONVERT (exactly 8 cycles): shift-add-3 over the 8-bit remaining, one bit per cycle. The full
//    disp_data word is written atomically on the 8th edge; intermediate values never appear.
//   WAIT_REL: both pressed levels must be released for DEBOUNCE_CYCLES consecutive cycles, then
//    return to IDLE. A held button therefore yields exactly one action.
//  Latency: taking the debounce-accept edge as edge 0, remaining, player and flags update at edge 1,
//   and disp_data updates at edge 9.
//  Arithmetic: the compare and subtract are 8-bit unsigned, and 999 always fits in the BCD output.
//   dipswitches=0 is illegal. With MAX_TAKE=10, values 11..15 are illegal.
// TESTING (DEBOUNCE_CYCLES=4 in sim)
//  1 reset -> disp_data=16'h1100, remaining=100, player=1, game_over=0, move_err=0.
//  2 dip=7, take held 20 cycles -> one move: remaining=93, player=2, disp_data=16'h2093 9 cycles
//    after accept. After release, a second press with dip=10 -> remaining=83, disp_data=16'h1083.
//  3 take low for 2 cycles only (glitch) -> no accept; all outputs unchanged.
//  4 dip=0, then dip=11 -> move_err=1, disp_data={player,12'hEEE}, remaining unchanged.
//    A following dip=1 -> move_err=0, remaining decrements by 1.
//  5 remaining=3, player=2: dip=5 -> move_err. dip=3 -> remaining=0, game_over=1, player=2,
//    disp_data=16'h2000. A further take is ignored; new -> disp_data=16'h1100, game_over=0.
//  6 rst_n pulsed low mid-CONVERT; also take and new accepted on the same cycle -> reset values
//    restored immediately; the simultaneous press resolves as a new game.

Source files
------------

// File: rtl/match_game_if.sv
// match_game_if: buttons/dipswitches in, display word, count and status flags out
interface match_game_if;
  logic [3:0]  dipswitches;
  logic        btn_take_n;
  logic        btn_new_n;
  logic [15:0] disp_data;
  logic [7:0]  remaining;
  logic [1:0]  player;
  logic        move_err;
  logic        game_over;
  logic        busy;
  modport master (
    output dipswitches, btn_take_n, btn_new_n,
    input  disp_data, remaining, player, move_err, game_over, busy
  );
  modport slave (
    input  dipswitches, btn_take_n, btn_new_n,
    output disp_data, remaining, player, move_err, game_over, busy
  );
endinterface

// File: rtl/match_game_controller.sv
// match_game_controller: debounced two-player match-stick game sequencer with sequential BCD display conversion
// Ports: clk, rst_n (async active-low); io.slave carries dipswitches, btn_take_n, btn_new_n in and
// disp_data {player,hundreds,tens,ones}, remaining, player, move_err, game_over, busy out.
module match_game_controller #(
  parameter int START_COUNT     = 100,
  parameter int MAX_TAKE        = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic          clk,
  input logic          rst_n,
  match_game_if.slave  io
);
  localparam logic [1:0] IDLE = 2'd0, APPLY = 2'd1, CONVERT = 2'd2, WAIT_REL = 2'd3;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [7:0]  START = 8'(START_COUNT);
  localparam logic [11:0] START_BCD = {4'(START_COUNT / 100), 4'((START_COUNT / 10) % 10), 4'(START_COUNT % 10)};
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] state, take_s, new_s, player;
  logic [CW-1:0] take_cnt, new_cnt, rel_cnt;
  logic [3:0] dip_q;
  logic is_new, move_err, game_over;
  logic [7:0] remaining, rem_sub;
  logic [15:0] disp_data;
  logic [19:0] dd, dd_nx;
  logic [11:0] adj;
  logic [2:0] bit_cnt;
  logic take_p, new_p, take_ok, new_ok, legal;
  assign take_p  = ~take_s[1];
  assign new_p   = ~new_s[1];
  assign take_ok = take_p && take_cnt == LAST;
  assign new_ok  = new_p && new_cnt == LAST;
  assign legal   = dip_q != 4'd0 && dip_q <= 4'(MAX_TAKE) && {4'd0, dip_q} <= remaining;
  assign rem_sub = remaining - {4'd0, dip_q};
  // double-dabble step: add 3 to any BCD digit >= 5, then shift {bcd,bin} left by one
  assign adj = {dd[19:16] > 4'd4 ? dd[19:16] + 4'd3 : dd[19:16],
                dd[15:12] > 4'd4 ? dd[15:12] + 4'd3 : dd[15:12],
                dd[11:8]  > 4'd4 ? dd[11:8]  + 4'd3 : dd[11:8]};
  assign dd_nx = {adj[10:0], dd[7:0], 1'b0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      take_s    <= 2'b11;
      new_s     <= 2'b11;
      take_cnt  <= '0;
      new_cnt   <= '0;
      rel_cnt   <= '0;
      dip_q     <= '0;
      is_new    <= 1'b0;
      remaining <= START;
      player    <= 2'd1;
      move_err  <= 1'b0;
      game_over <= 1'b0;
      disp_data <= {4'h1, START_BCD};
      dd        <= '0;
      bit_cnt   <= '0;
    end else begin
      take_s <= {take_s[0], io.btn_take_n};
      new_s  <= {new_s[0], io.btn_new_n};
      case (state)
        IDLE: begin
          take_cnt <= (take_p && !(take_ok || new_ok)) ? take_cnt + 1'b1 : '0;
          new_cnt  <= (new_p && !(take_ok || new_ok)) ? new_cnt + 1'b1 : '0;
          if (take_ok || new_ok) begin
            state  <= APPLY;
            is_new <= new_ok;
            dip_q  <= io.dipswitches;
          end
        end
        APPLY: begin
          bit_cnt <= '0;
          if (is_new) begin
            remaining <= START;
            player    <= 2'd1;
            move_err  <= 1'b0;
            game_over <= 1'b0;
            dd        <= {12'd0, START};
            state     <= CONVERT;
          end else if (game_over) begin
            state <= WAIT_REL;
          end else if (legal) begin
            remaining <= rem_sub;
            move_err  <= 1'b0;
            game_over <= rem_sub == 8'd0;
            player    <= rem_sub == 8'd0 ? player : 2'd3 - player;
            dd        <= {12'd0, rem_sub};
            state     <= CONVERT;
          end else begin
            move_err  <= 1'b1;
            disp_data <= {2'b00, player, 12'hEEE};
            state     <= WAIT_REL;
          end
        end
        CONVERT: begin
          dd      <= dd_nx;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            disp_data <= {2'b00, player, dd_nx[19:8]};
            state     <= WAIT_REL;
          end
        end
        default: begin
          rel_cnt <= (take_p || new_p || rel_cnt == LAST) ? '0 : rel_cnt + 1'b1;
          if (!(take_p || new_p) && rel_cnt == LAST) state <= IDLE;
        end
      endcase
    end
  end
  assign io.disp_data = disp_data;
  assign io.remaining = remaining;
  assign io.player    = player;
  assign io.move_err  = move_err;
  assign io.game_over = game_over;
  assign io.busy      = state == APPLY || state == CONVERT;
endmodule

// File: tb/tb_match_game_controller.sv
// tb_match_game_controller: directed-vector check of the match game controller with DEBOUNCE_CYCLES=4
module tb_match_game_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  match_game_if bus ();
  match_game_controller #(.START_COUNT(100), .MAX_TAKE(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic t, input logic nw, input logic [3:0] d, input int hold);
    bus.dipswitches = d;
    bus.btn_take_n = ~t;
    bus.btn_new_n = ~nw;
    tick(hold);
    bus.btn_take_n = 1'b1;
    bus.btn_new_n = 1'b1;
    tick(12);
  endtask
  task automatic status(input string tag, input logic [7:0] rem, input logic [1:0] pl, input logic [15:0] disp,
                        input logic err, input logic over);
    chk({tag, "_rem"}, 16'(bus.remaining), 16'(rem));
    chk({tag, "_pl"}, 16'(bus.player), 16'(pl));
    chk({tag, "_disp"}, bus.disp_data, disp);
    chk({tag, "_err"}, 16'(bus.move_err), 16'(err));
    chk({tag, "_over"}, 16'(bus.game_over), 16'(over));
    chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
  endtask
  initial begin
    int t_rem, t_disp;
    bus.dipswitches = 4'd0;
    bus.btn_take_n = 1'b1;
    bus.btn_new_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    status("reset", 8'd100, 2'd1, 16'h1100, 1'b0, 1'b0);
    // first take: measure latency of count and display from the press
    bus.dipswitches = 4'd7;
    bus.btn_take_n = 1'b0;
    t_rem = 0;
    t_disp = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (t_rem == 0 && bus.remaining != 8'd100) t_rem = i;
      if (t_disp == 0 && bus.disp_data != 16'h1100) t_disp = i;
    end
    chk("lat_rem", 16'(t_rem), 16'd7);
    chk("lat_disp", 16'(t_disp), 16'd15);
    bus.btn_take_n = 1'b1;
    tick(12);
    status("take7", 8'd93, 2'd2, 16'h2093, 1'b0, 1'b0);
    press(1'b1, 1'b0, 4'd10, 20);
    status("take10", 8'd83, 2'd1, 16'h1083, 1'b0, 1'b0);
    press(1'b1, 1'b0, 4'd5, 2);
    status("glitch", 8'd83, 2'd1, 16'h1083, 1'b0, 1'b0);
    press(1'b1, 1'b0, 4'd0, 20);
    status("dip0", 8'd83, 2'd1, 16'h1EEE, 1'b1, 1'b0);
    press(1'b1, 1'b0, 4'd11, 20);
    status("dip11", 8'd83, 2'd1, 16'h1EEE, 1'b1, 1'b0);
    press(1'b1, 1'b0, 4'd1, 20);
    status("dip1", 8'd82, 2'd2, 16'h2082, 1'b0, 1'b0);
    press(1'b1, 1'b0, 4'd9, 20);
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 4'd10, 20);
    status("to3", 8'd3, 2'd2, 16'h2003, 1'b0, 1'b0);
    press(1'b1, 1'b0, 4'd5, 20);
    status("over_take", 8'd3, 2'd2, 16'h2EEE, 1'b1, 1'b0);
    press(1'b1, 1'b0, 4'd3, 20);
    status("last", 8'd0, 2'd2, 16'h2000, 1'b0, 1'b1);
    press(1'b1, 1'b0, 4'd1, 20);
    status("ignored", 8'd0, 2'd2, 16'h2000, 1'b0, 1'b1);
    press(1'b0, 1'b1, 4'd1, 20);
    status("newgame", 8'd100, 2'd1, 16'h1100, 1'b0, 1'b0);
    // reset in the middle of a conversion
    bus.dipswitches = 4'd2;
    bus.btn_take_n = 1'b0;
    t_rem = 0;
    for (int i = 1; i <= 20 && t_rem == 0; i++) begin
      @(negedge clk);
      if (bus.remaining != 8'd100) t_rem = i;
    end
    chk("mid_rem", 16'(bus.remaining), 16'd98);
    tick(3);
    chk("mid_busy", 16'(bus.busy), 16'd1);
    rst_n = 1'b0;
    bus.btn_take_n = 1'b1;
    #1;
    chk("arst_rem", 16'(bus.remaining), 16'd100);
    chk("arst_pl", 16'(bus.player), 16'd1);
    chk("arst_disp", bus.disp_data, 16'h1100);
    chk("arst_busy", 16'(bus.busy), 16'd0);
    tick(3);
    rst_n = 1'b1;
    tick(12);
    status("post_rst", 8'd100, 2'd1, 16'h1100, 1'b0, 1'b0);
    press(1'b1, 1'b0, 4'd4, 20);
    status("take4", 8'd96, 2'd2, 16'h2096, 1'b0, 1'b0);
    press(1'b1, 1'b1, 4'd5, 20);
    status("both", 8'd100, 2'd1, 16'h1100, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
